// File: rtl/shift_add_multiplier.sv
// Iterative signed shift-and-add multiplier.
// The operand magnitudes are multiplied unsigned, one multiplier bit per
// cycle. The sign is applied once at the end. The result is the low WIDTH
// bits of the signed product, with a flag that is set when the product
// overflows WIDTH bits.
//
// Handshake (pulse style): a start is accepted on any rising edge where
// ctrl_MULT is high. This holds in every state, so a start during RUN or
// DONE abandons the operation in flight. data_resultRDY is a one-cycle pulse.
// It is asserted in the cycle after the DONE edge, WIDTH+1 edges after the
// start edge. busy is high from the start edge until the DONE edge.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             sign_neg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    product;
  logic             overflow;

  // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number, so no saturation is needed.
  // The signed product is then formed, and the overflow check requires that
  // the upper half plus the result sign bit are all copies of one bit.
  always_comb begin
    abs_a    = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    abs_b    = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    product  = sign_neg ? (~acc + PW'(1)) : acc;
    overflow = !((&product[PW-1:WIDTH-1]) || !(|product[PW-1:WIDTH-1]));
  end

  // Control FSM and datapath.
  // A start request takes priority over every state, including DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      sign_neg       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        sign_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        mcand    <= {{WIDTH{1'b0}}, abs_a};
        mplier   <= abs_b;
        acc      <= '0;
        count    <= '0;
        busy     <= 1'b1;
        state    <= RUN;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= {mcand[PW-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state <= DONE;
            end
          end
          DONE: begin
            data_result    <= product[WIDTH-1:0];
            data_exception <= overflow;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier (WIDTH=32).
// The reference model multiplies with 64-bit signed arithmetic and times the
// RDY pulse with a countdown from the start edge. One compare process checks
// every output on every falling edge. The test-plan vectors are also pinned
// against literal expectations.
module tb_shift_add_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic checking = 1'b0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Clock generation.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: the full signed product, then truncation.
  function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[W-1:0];
    e = (p != longint'($signed(p[W-1:0])));
  endfunction

  // Behavioural model: latched operands plus an edge countdown.
  logic         m_pending = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_res = '0;
  logic         m_exc = 1'b0;
  logic         m_rdy = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pending = 1'b0;
      m_left    = 0;
      m_res     = '0;
      m_exc     = 1'b0;
      m_rdy     = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (ctrl_MULT) begin
        m_pending = 1'b1;
        m_left    = LAT;
        m_a       = data_operandA;
        m_b       = data_operandB;
      end else if (m_pending) begin
        m_left--;
        if (m_left == 0) begin
          ref_mul(m_a, m_b, m_res, m_exc);
          m_rdy     = 1'b1;
          m_pending = 1'b0;
        end
      end
    end
  end

  // Compare process: every output is checked on every falling edge.
  always @(negedge clock) begin
    if (checking) begin
      check("rdy",       64'(data_resultRDY), 64'(m_rdy));
      check("busy",      64'(busy),           64'(m_pending));
      check("result",    64'(data_result),    64'(m_res));
      check("exception", 64'(data_exception), 64'(m_exc));
    end
  end

  // Drive a start pulse. Call this 1ns after a rising edge.
  // On return, the time is 1ns after the start edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait (bounded) for RDY. Returns the number of edges after the start edge.
  task automatic wait_rdy(output int n);
    n = 0;
    while (n < LAT + 7) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) break;
    end
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ee, input string tag);
    logic [W-1:0] r;
    logic e;
    int n;
    ref_mul(a, b, r, e);
    check({tag, "_model_pin"}, {31'd0, r, e}, {31'd0, er, ee});
    do_start(a, b);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_rdy(n);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_result"}, 64'(data_result), 64'(er));
    check({tag, "_exception"}, 64'(data_exception), 64'(ee));
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
    check({tag, "_hold"}, 64'(data_result), 64'(er));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int rdy_seen;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset block.
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exception", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset_n  = 1'b1;
    checking = 1'b1;
    @(posedge clock);
    #1;

    // Directed vectors with literal expectations.
    run_vec(32'd6,          32'd7,          32'd42,         1'b0, "six_seven");
    run_vec(32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0, "neg3_5");
    run_vec(32'hFFFF_FFFC,  32'hFFFF_FFFC,  32'd16,         1'b0, "neg4_neg4");
    run_vec(32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, "max_2");
    run_vec(32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, "min_1");
    run_vec(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "min_neg1");
    run_vec(32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, "two16_sq");
    run_vec(32'd0,          32'h8000_0000,  32'd0,          1'b0, "zero_min");

    // Restart at cycle 10 of a 6*7 operation.
    do_start(32'd6, 32'd7);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    do_start(32'd3, 32'd3);
    wait_rdy(n);
    check("restart_latency", 64'(n), 64'(LAT));
    check("restart_result", 64'(data_result), 64'd9);
    @(posedge clock);
    #1;

    // Asynchronous reset during an operation.
    do_start(32'd6, 32'd7);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_result", 64'(data_result), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    rdy_seen = 0;
    repeat (LAT + 6) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    check("no_rdy_after_reset", 64'(rdy_seen), 64'd0);
    run_vec(32'd2, 32'd2, 32'd4, 1'b0, "after_reset");

    // Randomized operations, with random restarts (the DONE edge included).
    for (int i = 0; i < 200; i++) begin
      a = pick();
      b = pick();
      do_start(a, b);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, LAT - 1)) begin
          @(posedge clock);
          #1;
        end
      end else begin
        wait_rdy(n);
        check("rand_latency", 64'(n), 64'(LAT));
        repeat ($urandom_range(0, 3)) begin
          @(posedge clock);
          #1;
        end
      end
    end
    wait_rdy(n);
    repeat (3) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Iterative signed multiplier that sits directly downstream of the ALU's 1-bit logical-left-shift stage.
- Each iteration conditionally accumulates the multiplicand, then advances the multiplicand by one logical-left-shift-by-one (LSB filled with 0) and the multiplier by one logical right shift.
- Produces the low WIDTH bits of the signed product plus an overflow flag for the processor's multdiv path.
- Start/ready pulse handshake; fixed latency.

Parameters:
- WIDTH, 32, operand and result width in bits. All test values below assume 32.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_MULT  input  1  start pulse; operands sampled on the rising edge where it is high.
- data_operandA  input  WIDTH  signed multiplicand.
- data_operandB  input  WIDTH  signed multiplier.
- data_result  output  WIDTH  low WIDTH bits of the signed product.
- data_exception  output  1  signed overflow: the product does not fit in WIDTH bits.
- data_resultRDY  output  1  one-cycle done pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset_n low, asynchronous):
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal state: IDLE, counter=0, accumulator=0.
  - Reset mid-operation abandons the operation; no RDY pulse follows.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with ctrl_MULT=1 (edge T):
  - Latch sign_neg = A[msb] XOR B[msb].
  - Latch mcand = |A| zero-extended to 2*WIDTH.
  - Latch mplier = |B| as a WIDTH-bit unsigned value. |-2^(WIDTH-1)| = 2^(WIDTH-1) exactly; no saturation.
  - Set acc=0, count=0, go to RUN, busy=1.
- RUN: one iteration per edge:
  - If mplier[0], acc = acc + mcand (2*WIDTH-bit add, carry discarded).
  - mcand = mcand logically shifted left by 1, LSB=0.
  - mplier = mplier logically shifted right by 1.
  - count++.
  - After the WIDTH-th iteration (edge T+WIDTH), go to DONE.
- DONE (edge T+WIDTH+1):
  - P = sign_neg ? two's-complement negate(acc) : acc.
  - data_result = P[WIDTH-1:0].
  - data_exception = 1 iff bits P[2*WIDTH-1:WIDTH-1] are not all equal.
  - data_resultRDY = 1 for exactly this one cycle; busy = 0; go to IDLE.
- Latency: RDY is high in the cycle following edge T+WIDTH+1, i.e. T+33 for WIDTH=32.
- Hold: data_result and data_exception hold their values until the next DONE or reset. RDY drops at the next edge.
- Zero operand: still takes the full WIDTH+1 cycles (fixed latency). Result 0, exception 0. The sign of a zero product is irrelevant because negating 0 yields 0.
- Restart: ctrl_MULT=1 while in RUN or DONE aborts the current operation and restarts with the newly sampled operands. No RDY is issued for the aborted operation.
  - If restart coincides with the DONE edge, the restart takes priority: outputs are not updated and RDY stays 0.
- Operand inputs are ignored except on the start edge; changing them mid-operation has no effect.

Test Plan:
- Reset then A=6, B=7, pulse ctrl_MULT -> exactly 33 cycles later RDY=1 for one cycle; result=42, exception=0; busy high for cycles 1..32.
- A=-3 (0xFFFFFFFD), B=5 -> result=0xFFFFFFF1 (-15), exception=0. A=-4, B=-4 -> result=16, exception=0.
- A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0. A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- A=0x00010000, B=0x00010000 -> result=0, exception=1. A=0, B=0x80000000 -> result=0, exception=0, still 33-cycle latency.
- Start 6*7, re-pulse ctrl_MULT at cycle 10 with A=3, B=3 -> no RDY at the original cycle 33; RDY 33 cycles after the restart edge with result=9.
- Start 6*7, drive reset_n low at cycle 15 between edges -> outputs 0 immediately (asynchronous). Release reset -> no RDY appears; a fresh 2*2 returns 4 after 33 cycles.
